// File: rtl/detect_programmable_sequence_using_fsm.sv
// Serial bit-sequence detector with a runtime-loadable pattern of 1..MAX_LEN bits,
// per-bit valid qualifier, overlap/non-overlap modes and a saturating match counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// UNCFG | no legal configuration loaded; serial input ignored
// RUN   | pattern active; valid bits shifted into history and matched
module detect_programmable_sequence_using_fsm #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a,
    input  logic               a_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;

    logic               len_ok;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [LEN_W-1:0]   fill_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;

    always_comb begin
        len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        hist_nxt = {hist_q[MAX_LEN-2:0], a};
        fill_nxt = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        // len_q == MAX_LEN shifts every one out, leaving a full-width mask
        len_mask = ~({MAX_LEN{1'b1}} << len_q);
        hit      = ((hist_nxt & len_mask) == (pat_q & len_mask)) && (fill_nxt >= len_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= UNCFG;
            armed       <= 1'b0;
            detected    <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
        end else begin
            detected <= 1'b0;
            cfg_err  <= 1'b0;
            // A load strobe owns the cycle: any serial bit alongside it is dropped
            if (cfg_load) begin
                if (len_ok) begin
                    state       <= RUN;
                    armed       <= 1'b1;
                    pat_q       <= cfg_pattern;
                    len_q       <= cfg_len;
                    ovl_q       <= cfg_overlap;
                    hist_q      <= '0;
                    fill_q      <= '0;
                    match_count <= '0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else begin
                case (state)
                    UNCFG: begin
                        armed <= 1'b0;
                    end
                    RUN: begin
                        armed <= 1'b1;
                        if (a_valid) begin
                            hist_q <= hist_nxt;
                            if (hit) begin
                                detected <= 1'b1;
                                if (match_count != '1) begin
                                    match_count <= match_count + 1'b1;
                                end
                                fill_q <= ovl_q ? fill_nxt : '0;
                            end else begin
                                fill_q <= fill_nxt;
                            end
                        end
                    end
                    default: begin
                        state <= UNCFG;
                        armed <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
